udp_tx_protocol: RTL and testbench

Layer-4 UDP transmitter. It sits between application-layer UDP senders and the IPv4 transmit path, mirroring the UDP receive logic in the stack. It buffers one whole datagram and accumulates the checksum while buffering. On commit it emits the UDP header, with the checksum computed over the pseudo-header, followed by the payload on the layer-3 bus. Nothing reaches layer 3 until the application commits a well-formed datagram, so layer 3 never sees a partial datagram.

---
 rtl/udp_tx_protocol_pkg.sv | 42 ++++
 rtl/udp_tx_protocol_if.sv | 59 +++++
 rtl/udp_tx_buffer.sv | 34 +++
 rtl/udp_tx_protocol.sv | 265 ++++++++++++++++++++++++++
 tb/tb_udp_tx_protocol.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_tx_protocol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udp_tx_protocol_pkg
//  Description : Shared types and constants for the UDP transmit path.
//                Holds the FSM state encoding, the UDP protocol number, the
//                UDP header length and the byte-mask helper used when a
//                partial word is added to the checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
package udp_tx_protocol_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_BUFFER    = 4'd1,
    ST_DISCARD   = 4'd2,
    ST_CSUM      = 4'd3,
    ST_HDR_START = 4'd4,
    ST_HDR_PORTS = 4'd5,
    ST_HDR_LEN   = 4'd6,
    ST_BODY      = 4'd7,
    ST_COMMIT    = 4'd8
  } state_t;

  localparam logic [7:0]  c_UDP_PROTOCOL = 8'h11;
  localparam logic [15:0] c_UDP_HDR_LEN  = 16'd8;

  // Zero the unused low-order bytes of an MSB-first word so that padding
  // never contributes to the checksum.
  function automatic logic [31:0] mask_word(input logic [31:0] w,
                                            input logic [2:0]  bv);
    logic [31:0] m;
    case (bv)
      3'd1:    m = w & 32'hFF00_0000;
      3'd2:    m = w & 32'hFFFF_0000;
      3'd3:    m = w & 32'hFFFF_FF00;
      default: m = w;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_tx_protocol_if.sv
`default_nettype none
// ============================================================================
//  Module      : udp_tx_protocol_if
//  Description : Layer-4 application bus and layer-3 IPv4 transmit bus of
//                the UDP transmitter.
//                slave  : view of the UDP transmitter itself
//                master : view of the application / IP layer around it
//  Revision    : 1.0 - initial release
// ============================================================================
interface udp_tx_protocol_if;
  import udp_tx_protocol_pkg::*;

  // layer 4 (application -> UDP)
  logic        tx_l4_ready;
  logic        tx_l4_start;
  logic [31:0] tx_l4_dst_ip;
  logic [15:0] tx_l4_src_port;
  logic [15:0] tx_l4_dst_port;
  logic [15:0] tx_l4_payload_len;
  logic        tx_l4_data_valid;
  logic [2:0]  tx_l4_bytes_valid;
  logic [31:0] tx_l4_data;
  logic        tx_l4_commit;
  logic        tx_l4_drop;
  logic        tx_l4_error;

  // layer 3 (UDP -> IPv4)
  logic        tx_l3_start;
  logic [31:0] tx_l3_dst_ip;
  logic [15:0] tx_l3_payload_len;
  logic        tx_l3_protocol_is_udp;
  logic        tx_l3_data_valid;
  logic [2:0]  tx_l3_bytes_valid;
  logic [31:0] tx_l3_data;
  logic        tx_l3_commit;
  logic        tx_l3_drop;

  modport slave (
    input  tx_l4_start, tx_l4_dst_ip, tx_l4_src_port, tx_l4_dst_port,
           tx_l4_payload_len, tx_l4_data_valid, tx_l4_bytes_valid,
           tx_l4_data, tx_l4_commit, tx_l4_drop,
    output tx_l4_ready, tx_l4_error,
           tx_l3_start, tx_l3_dst_ip, tx_l3_payload_len,
           tx_l3_protocol_is_udp, tx_l3_data_valid, tx_l3_bytes_valid,
           tx_l3_data, tx_l3_commit, tx_l3_drop
  );

  modport master (
    output tx_l4_start, tx_l4_dst_ip, tx_l4_src_port, tx_l4_dst_port,
           tx_l4_payload_len, tx_l4_data_valid, tx_l4_bytes_valid,
           tx_l4_data, tx_l4_commit, tx_l4_drop,
    input  tx_l4_ready, tx_l4_error,
           tx_l3_start, tx_l3_dst_ip, tx_l3_payload_len,
           tx_l3_protocol_is_udp, tx_l3_data_valid, tx_l3_bytes_valid,
           tx_l3_data, tx_l3_commit, tx_l3_drop
  );

endinterface
`default_nettype wire

// File: rtl/udp_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : udp_tx_buffer
//  Description : Simple dual-port payload RAM, DEPTH_WORDS x 32, one write
//                port and one registered read port (1-cycle latency). The
//                read data holds its value between reads.
//  Ports       : clk               clock
//                wr_en/addr/data   write port
//                rd_en/addr        read request
//                rd_data           read data, valid the cycle after rd_en
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_buffer #(
  parameter int DEPTH_WORDS = 512,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  wire logic              clk,
  input  wire logic              wr_en,
  input  wire logic [ADDR_W-1:0] wr_addr,
  input  wire logic [31:0]       wr_data,
  input  wire logic              rd_en,
  input  wire logic [ADDR_W-1:0] rd_addr,
  output      logic [31:0]       rd_data
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/udp_tx_protocol.sv
`default_nettype none
// ============================================================================
//  Module      : udp_tx_protocol
//  Description : Layer-4 UDP transmitter. Buffers one whole datagram while
//                accumulating its checksum, then emits the UDP header and
//                the payload on the layer-3 bus. Malformed or dropped
//                datagrams never reach layer 3.
//  Ports       : clk     clock
//                rst     asynchronous active-high reset
//                our_ip  local IPv4 address (pseudo-header only)
//                bus     udp_tx_protocol_if.slave (layer-4 in, layer-3 out)
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_protocol
  import udp_tx_protocol_pkg::*;
#(
  parameter int DEPTH_WORDS = 512
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] our_ip,
  udp_tx_protocol_if.slave bus
);

  localparam int          c_AW        = $clog2(DEPTH_WORDS);
  localparam logic [16:0] c_MAX_BYTES = 17'(DEPTH_WORDS * 4);
  localparam logic [c_AW:0] c_WPTR_FULL = (c_AW + 1)'(DEPTH_WORDS);

  state_t r_state, w_state_next;

  logic [c_AW:0]   r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [15:0]     r_byte_cnt;
  logic [31:0]     r_sum;
  logic [31:0]     r_dst_ip;
  logic [15:0]     r_src_port, r_dst_port, r_plen, r_len, r_csum;
  logic [15:0]     r_last_idx;
  logic [2:0]      r_last_bv;
  logic            r_short_seen;
  logic            r_error;

  logic            w_accept, w_wr, w_err, w_rd_en, w_ready;
  logic [c_AW-1:0] w_rd_addr;
  logic            w_l3_start, w_l3_valid, w_l3_commit;
  logic [2:0]      w_l3_bv;
  logic [31:0]     w_l3_data;
  logic [31:0]     w_rd_data;

  // ---------------------------------------------------------------- datapath
  logic [15:0] w_len_in;
  logic [31:0] w_seed;
  logic [15:0] w_cnt_next;
  logic [31:0] w_masked;
  logic        w_oversize, w_bad_bv, w_bad_word, w_is_last;
  logic [16:0] w_fold1, w_fold2;
  logic [15:0] w_csum;

  assign w_len_in   = bus.tx_l4_payload_len + c_UDP_HDR_LEN;
  assign w_oversize = {1'b0, bus.tx_l4_payload_len} > c_MAX_BYTES;

  // Pseudo-header plus UDP header (checksum field taken as zero).
  assign w_seed = {16'd0, our_ip[31:16]} + {16'd0, our_ip[15:0]}
                + {16'd0, bus.tx_l4_dst_ip[31:16]} + {16'd0, bus.tx_l4_dst_ip[15:0]}
                + {24'd0, c_UDP_PROTOCOL} + {16'd0, w_len_in}
                + {16'd0, bus.tx_l4_src_port} + {16'd0, bus.tx_l4_dst_port}
                + {16'd0, w_len_in};

  assign w_cnt_next = r_byte_cnt + {13'd0, bus.tx_l4_bytes_valid};
  assign w_masked   = mask_word(bus.tx_l4_data, bus.tx_l4_bytes_valid);

  // A short word is only legal as the final one, so any word that follows
  // a short word is malformed.
  assign w_bad_bv   = (bus.tx_l4_bytes_valid == 3'd0) || (bus.tx_l4_bytes_valid > 3'd4);
  assign w_bad_word = (r_wptr == c_WPTR_FULL) || r_short_seen || w_bad_bv;

  assign w_is_last  = (16'(r_rptr) == r_last_idx);

  // Two end-around folds suffice: the first leaves at most 0x1FFFE.
  assign w_fold1 = {1'b0, r_sum[31:16]} + {1'b0, r_sum[15:0]};
  assign w_fold2 = {16'd0, w_fold1[16]} + {1'b0, w_fold1[15:0]};
  assign w_csum  = (~w_fold2[15:0] == 16'h0000) ? 16'hFFFF : ~w_fold2[15:0];

  // --------------------------------------------------------------- FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // ------------------------------------------------ FSM next-state / outputs
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_wr         = 1'b0;
    w_err        = 1'b0;
    w_rd_en      = 1'b0;
    w_rd_addr    = '0;
    w_ready      = 1'b0;
    w_l3_start   = 1'b0;
    w_l3_valid   = 1'b0;
    w_l3_bv      = 3'd0;
    w_l3_data    = 32'd0;
    w_l3_commit  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.tx_l4_start) begin
          if (w_oversize) begin
            w_err        = 1'b1;
            w_state_next = ST_DISCARD;
          end else begin
            w_accept     = 1'b1;
            w_state_next = ST_BUFFER;
          end
        end
      end

      ST_BUFFER: begin
        if (bus.tx_l4_drop) begin
          w_state_next = ST_IDLE;
        end else if (bus.tx_l4_data_valid && w_bad_word) begin
          w_err        = 1'b1;
          // A commit in the same cycle already closes the datagram.
          w_state_next = bus.tx_l4_commit ? ST_IDLE : ST_DISCARD;
        end else begin
          w_wr = bus.tx_l4_data_valid;
          if (bus.tx_l4_commit) begin
            if ((bus.tx_l4_data_valid ? w_cnt_next : r_byte_cnt) == r_plen) begin
              w_state_next = ST_CSUM;
            end else begin
              w_err        = 1'b1;
              w_state_next = ST_IDLE;
            end
          end
        end
      end

      ST_DISCARD: begin
        if (bus.tx_l4_commit || bus.tx_l4_drop) w_state_next = ST_IDLE;
      end

      ST_CSUM: begin
        w_rd_en      = 1'b1;
        w_rd_addr    = '0;
        w_state_next = ST_HDR_START;
      end

      ST_HDR_START: begin
        w_l3_start   = 1'b1;
        w_state_next = ST_HDR_PORTS;
      end

      ST_HDR_PORTS: begin
        w_l3_valid   = 1'b1;
        w_l3_bv      = 3'd4;
        w_l3_data    = {r_src_port, r_dst_port};
        w_state_next = ST_HDR_LEN;
      end

      ST_HDR_LEN: begin
        w_l3_valid   = 1'b1;
        w_l3_bv      = 3'd4;
        w_l3_data    = {r_len, r_csum};
        w_state_next = (r_plen == 16'd0) ? ST_COMMIT : ST_BODY;
      end

      ST_BODY: begin
        w_l3_valid = 1'b1;
        w_l3_bv    = w_is_last ? r_last_bv : 3'd4;
        w_l3_data  = w_rd_data;
        // Prefetch the next word so the body streams without bubbles.
        w_rd_en    = 1'b1;
        w_rd_addr  = r_rptr + c_AW'(1);
        if (w_is_last) w_state_next = ST_COMMIT;
      end

      ST_COMMIT: begin
        w_l3_commit  = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_byte_cnt   <= '0;
      r_sum        <= '0;
      r_dst_ip     <= '0;
      r_src_port   <= '0;
      r_dst_port   <= '0;
      r_plen       <= '0;
      r_len        <= '0;
      r_csum       <= '0;
      r_last_idx   <= '0;
      r_last_bv    <= '0;
      r_short_seen <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_error <= w_err;

      if (w_accept) begin
        r_dst_ip     <= bus.tx_l4_dst_ip;
        r_src_port   <= bus.tx_l4_src_port;
        r_dst_port   <= bus.tx_l4_dst_port;
        r_plen       <= bus.tx_l4_payload_len;
        r_len        <= w_len_in;
        r_sum        <= w_seed;
        r_wptr       <= '0;
        r_byte_cnt   <= '0;
        r_short_seen <= 1'b0;
        r_last_idx   <= ((bus.tx_l4_payload_len + 16'd3) >> 2) - 16'd1;
        r_last_bv    <= (bus.tx_l4_payload_len[1:0] == 2'd0) ? 3'd4
                                                             : {1'b0, bus.tx_l4_payload_len[1:0]};
      end

      if (w_wr) begin
        r_sum        <= r_sum + {16'd0, w_masked[31:16]} + {16'd0, w_masked[15:0]};
        r_byte_cnt   <= w_cnt_next;
        r_wptr       <= r_wptr + (c_AW + 1)'(1);
        r_short_seen <= r_short_seen | (bus.tx_l4_bytes_valid != 3'd4);
      end

      if (r_state == ST_CSUM) begin
        r_csum <= w_csum;
        r_rptr <= '0;
      end

      if (r_state == ST_BODY) r_rptr <= r_rptr + c_AW'(1);
    end
  end

  // ---------------------------------------------------------------- storage
  udp_tx_buffer #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (c_AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (w_wr),
    .wr_addr (r_wptr[c_AW-1:0]),
    .wr_data (bus.tx_l4_data),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  // ----------------------------------------------------------------- outputs
  assign bus.tx_l4_ready           = w_ready;
  assign bus.tx_l4_error           = r_error;
  assign bus.tx_l3_start           = w_l3_start;
  assign bus.tx_l3_dst_ip          = r_dst_ip;
  assign bus.tx_l3_payload_len     = r_len;
  assign bus.tx_l3_protocol_is_udp = 1'b1;
  assign bus.tx_l3_data_valid      = w_l3_valid;
  assign bus.tx_l3_bytes_valid     = w_l3_bv;
  assign bus.tx_l3_data            = w_l3_data;
  assign bus.tx_l3_commit          = w_l3_commit;
  assign bus.tx_l3_drop            = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_protocol.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udp_tx_protocol
//  Description : Self-checking bench for udp_tx_protocol. A table of
//                datagrams with hand-computed checksums is pushed through
//                and the layer-3 stream is compared cycle by cycle; error,
//                drop and reset corner cases follow as directed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_protocol;

  localparam int          DEPTH_WORDS = 512;
  localparam logic [31:0] c_OUR_IP    = 32'h0A00_0001;
  localparam logic [31:0] c_DST_IP    = 32'h0A00_0002;
  localparam logic [15:0] c_SRC_PORT  = 16'd1234;
  localparam logic [15:0] c_DST_PORT  = 16'd5678;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] our_ip;

  udp_tx_protocol_if bus();

  udp_tx_protocol #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk    (clk),
    .rst    (rst),
    .our_ip (our_ip),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      plen;
    int               nwords;
    logic [2:0][31:0] words;
    logic [2:0]       last_bv;
    logic [15:0]      exp_csum;
  } vec_t;

  vec_t vecs [6];

  int n_checks    = 0;
  int n_errors    = 0;
  int n_l3_starts = 0;
  int n_l3_valids = 0;

  always @(posedge clk) begin
    if (bus.tx_l3_start)      n_l3_starts++;
    if (bus.tx_l3_data_valid) n_l3_valids++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [31:0] bmask(input logic [31:0] w, input logic [2:0] bv);
    if (bv == 3'd4) return w;
    return w & ~(32'hFFFF_FFFF >> (8 * bv));
  endfunction

  task automatic start_dgram(input logic [15:0] plen);
    bus.tx_l4_start       = 1'b1;
    bus.tx_l4_dst_ip      = c_DST_IP;
    bus.tx_l4_src_port    = c_SRC_PORT;
    bus.tx_l4_dst_port    = c_DST_PORT;
    bus.tx_l4_payload_len = plen;
    tick();
    bus.tx_l4_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] bv);
    bus.tx_l4_data_valid  = 1'b1;
    bus.tx_l4_data        = d;
    bus.tx_l4_bytes_valid = bv;
    tick();
    bus.tx_l4_data_valid  = 1'b0;
    bus.tx_l4_bytes_valid = 3'd0;
  endtask

  task automatic pulse_commit;
    bus.tx_l4_commit = 1'b1;
    tick();
    bus.tx_l4_commit = 1'b0;
  endtask

  task automatic pulse_drop;
    bus.tx_l4_drop = 1'b1;
    tick();
    bus.tx_l4_drop = 1'b0;
  endtask

  // Leaves the bench one cycle after the commit was sampled (CSUM cycle).
  task automatic send_vec(input vec_t v);
    start_dgram(v.plen);
    for (int i = 0; i < v.nwords; i++) begin
      send_word(v.words[i], (i == v.nwords - 1) ? v.last_bv : 3'd4);
      if (i == 0) tick();  // gap between application words
    end
    pulse_commit();
  endtask

  task automatic check_tx(input vec_t v, input string tag);
    logic [15:0] len, acc, exp_bv;
    int w;
    len = v.plen + 16'd8;
    w   = (int'(v.plen) + 3) / 4;
    acc = 16'd0;
    chk({tag, "_busy"}, {31'd0, bus.tx_l4_ready}, 32'd0);
    tick();
    chk({tag, "_l3_start"}, {31'd0, bus.tx_l3_start}, 32'd1);
    chk({tag, "_dst_ip"}, bus.tx_l3_dst_ip, c_DST_IP);
    chk({tag, "_l3_len"}, {16'd0, bus.tx_l3_payload_len}, {16'd0, len});
    chk({tag, "_start_novalid"}, {31'd0, bus.tx_l3_data_valid}, 32'd0);
    tick();
    chk({tag, "_ports_valid"}, {31'd0, bus.tx_l3_data_valid}, 32'd1);
    chk({tag, "_ports"}, bus.tx_l3_data, 32'h04D2_162E);
    chk({tag, "_ports_bv"}, {29'd0, bus.tx_l3_bytes_valid}, 32'd4);
    tick();
    chk({tag, "_lenck_valid"}, {31'd0, bus.tx_l3_data_valid}, 32'd1);
    chk({tag, "_len_csum"}, bus.tx_l3_data, {len, v.exp_csum});
    acc = oc_add(acc, c_OUR_IP[31:16]);
    acc = oc_add(acc, c_OUR_IP[15:0]);
    acc = oc_add(acc, c_DST_IP[31:16]);
    acc = oc_add(acc, c_DST_IP[15:0]);
    acc = oc_add(acc, 16'h0011);
    acc = oc_add(acc, len);
    acc = oc_add(acc, c_SRC_PORT);
    acc = oc_add(acc, c_DST_PORT);
    acc = oc_add(acc, len);
    acc = oc_add(acc, bus.tx_l3_data[15:0]);
    for (int k = 0; k < w; k++) begin
      tick();
      exp_bv = (k == w - 1) ? ((v.plen[1:0] == 2'd0) ? 16'd4 : {14'd0, v.plen[1:0]}) : 16'd4;
      chk({tag, "_body_valid"}, {31'd0, bus.tx_l3_data_valid}, 32'd1);
      chk({tag, "_body_data"}, bus.tx_l3_data, v.words[k]);
      chk({tag, "_body_bv"}, {29'd0, bus.tx_l3_bytes_valid}, {16'd0, exp_bv});
      acc = oc_add(acc, bmask(bus.tx_l3_data, exp_bv[2:0])[31:16]);
      acc = oc_add(acc, bmask(bus.tx_l3_data, exp_bv[2:0])[15:0]);
    end
    tick();
    chk({tag, "_l3_commit"}, {31'd0, bus.tx_l3_commit}, 32'd1);
    chk({tag, "_commit_novalid"}, {31'd0, bus.tx_l3_data_valid}, 32'd0);
    tick();
    chk({tag, "_ready_after"}, {31'd0, bus.tx_l4_ready}, 32'd1);
    chk({tag, "_ones_sum"}, {16'd0, acc}, 32'h0000_FFFF);
  endtask

  initial begin
    int s0, v0;

    vecs[0] = '{plen: 16'd4,  nwords: 1, words: {32'h0, 32'h0, 32'hDEAD_BEEF},
                last_bv: 3'd4, exp_csum: 16'h3336};
    vecs[1] = '{plen: 16'd5,  nwords: 2, words: {32'h0, 32'h5566_7788, 32'h1122_3344},
                last_bv: 3'd1, exp_csum: 16'h376B};
    vecs[2] = '{plen: 16'd0,  nwords: 0, words: {32'h0, 32'h0, 32'h0},
                last_bv: 3'd4, exp_csum: 16'hD0DB};
    vecs[3] = '{plen: 16'd12, nwords: 3, words: {32'h0005_0006, 32'h0003_0004, 32'h0001_0002},
                last_bv: 3'd4, exp_csum: 16'hD0AE};
    vecs[4] = '{plen: 16'd4,  nwords: 1, words: {32'h0, 32'h0, 32'hD0D3_0000},
                last_bv: 3'd4, exp_csum: 16'hFFFF};
    vecs[5] = '{plen: 16'd7,  nwords: 2, words: {32'h0, 32'h1122_33FF, 32'hAABB_CCDD},
                last_bv: 3'd3, exp_csum: 16'h1512};

    rst    = 1'b1;
    our_ip = c_OUR_IP;
    bus.tx_l4_start       = 1'b0;
    bus.tx_l4_dst_ip      = 32'd0;
    bus.tx_l4_src_port    = 16'd0;
    bus.tx_l4_dst_port    = 16'd0;
    bus.tx_l4_payload_len = 16'd0;
    bus.tx_l4_data_valid  = 1'b0;
    bus.tx_l4_bytes_valid = 3'd0;
    bus.tx_l4_data        = 32'd0;
    bus.tx_l4_commit      = 1'b0;
    bus.tx_l4_drop        = 1'b0;
    tick();
    tick();
    chk("rst_ready",    {31'd0, bus.tx_l4_ready},      32'd1);
    chk("rst_error",    {31'd0, bus.tx_l4_error},      32'd0);
    chk("rst_l3_start", {31'd0, bus.tx_l3_start},      32'd0);
    chk("rst_l3_valid", {31'd0, bus.tx_l3_data_valid}, 32'd0);
    chk("rst_l3_commit",{31'd0, bus.tx_l3_commit},     32'd0);
    rst = 1'b0;
    tick();

    // Table-driven datagrams
    for (int i = 0; i < 6; i++) begin
      send_vec(vecs[i]);
      check_tx(vecs[i], $sformatf("vec%0d", i));
    end

    // Length mismatch: 8 declared, 4 sent
    s0 = n_l3_starts; v0 = n_l3_valids;
    start_dgram(16'd8);
    send_word(32'hCAFE_F00D, 3'd4);
    pulse_commit();
    chk("mismatch_error", {31'd0, bus.tx_l4_error}, 32'd1);
    chk("mismatch_ready", {31'd0, bus.tx_l4_ready}, 32'd1);
    tick();
    chk("mismatch_err_pulse", {31'd0, bus.tx_l4_error}, 32'd0);
    repeat (4) tick();
    chk("mismatch_no_l3", n_l3_starts + n_l3_valids, s0 + v0);

    // Oversize: 2049 bytes
    s0 = n_l3_starts; v0 = n_l3_valids;
    start_dgram(16'd2049);
    chk("oversize_error", {31'd0, bus.tx_l4_error}, 32'd1);
    chk("oversize_busy",  {31'd0, bus.tx_l4_ready}, 32'd0);
    send_word(32'h1111_2222, 3'd4);
    send_word(32'h3333_4444, 3'd4);
    chk("oversize_discard", {31'd0, bus.tx_l4_ready}, 32'd0);
    pulse_commit();
    chk("oversize_ready", {31'd0, bus.tx_l4_ready}, 32'd1);
    repeat (4) tick();
    chk("oversize_no_l3", n_l3_starts + n_l3_valids, s0 + v0);

    // Short word that is not the last one
    s0 = n_l3_starts;
    start_dgram(16'd8);
    send_word(32'hAAAA_0000, 3'd2);
    send_word(32'hBBBB_CCCC, 3'd4);
    chk("short_error", {31'd0, bus.tx_l4_error}, 32'd1);
    chk("short_busy",  {31'd0, bus.tx_l4_ready}, 32'd0);
    pulse_commit();
    chk("short_ready", {31'd0, bus.tx_l4_ready}, 32'd1);
    repeat (3) tick();
    chk("short_no_l3", n_l3_starts, s0);

    // Drop mid-buffer, then a good datagram
    s0 = n_l3_starts;
    start_dgram(16'd8);
    send_word(32'h1234_5678, 3'd4);
    pulse_drop();
    chk("drop_ready", {31'd0, bus.tx_l4_ready}, 32'd1);
    chk("drop_silent", {31'd0, bus.tx_l4_error}, 32'd0);
    send_vec(vecs[0]);
    check_tx(vecs[0], "after_drop");
    chk("drop_one_start", n_l3_starts, s0 + 1);

    // Asynchronous reset in the middle of BODY
    send_vec(vecs[3]);
    repeat (4) tick();
    chk("midbody_valid", {31'd0, bus.tx_l3_data_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready",  {31'd0, bus.tx_l4_ready},      32'd1);
    chk("arst_valid",  {31'd0, bus.tx_l3_data_valid}, 32'd0);
    chk("arst_data",   bus.tx_l3_data,                32'd0);
    chk("arst_bv",     {29'd0, bus.tx_l3_bytes_valid}, 32'd0);
    chk("arst_commit", {31'd0, bus.tx_l3_commit},     32'd0);
    chk("arst_dst_ip", bus.tx_l3_dst_ip,              32'd0);
    chk("arst_len",    {16'd0, bus.tx_l3_payload_len}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    send_vec(vecs[1]);
    check_tx(vecs[1], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
